// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of an asynchronous FIFO.
// Synchronizes the Gray write pointer into rclk and keeps the binary and Gray
// read pointers. Produces the registered empty flag and occupancy, and the
// registered read data.
// Compile-time option: define RD_FWFT_EN for first-word-fall-through output.
// Without it, the block uses the standard pop-on-rinc output.
module fifo_rd_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rwptr,
    input  logic [DATASIZE-1:0] rmem_data,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   rlevel
);

    logic [ADDRSIZE:0] rq1, rq2;
    logic [ADDRSIZE:0] rbin, rbinnext, rgraynext, rwbin;
    logic              pop_req, pop;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Two-flop synchronizer: the only path from the write-domain pointer.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rwptr;
            rq2 <= rq1;
        end
    end

`ifdef RD_FWFT_EN
    // FWFT: fetch whenever the output register is free or being consumed.
    assign pop_req = !rvalid || rinc;
`else
    // Standard: each rinc requests one word.
    assign pop_req = rinc;
`endif

    // Next-pointer arithmetic shared by the pointer, flag and level registers.
    always_comb begin
        pop       = pop_req && !rempty;
        rbinnext  = rbin + {{ADDRSIZE{1'b0}}, pop};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        rwbin     = gray2bin(rq2);
    end

    assign raddr = rbin[ADDRSIZE-1:0];

    // Pointer, empty flag and occupancy all update on the same edge as a pop.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            rlevel <= '0;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= (rgraynext == rq2);
            rlevel <= rwbin - rbinnext;
        end
    end

    // Output data register; rvalid meaning depends on the output mode.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (pop) begin
            rdata  <= rmem_data;
            rvalid <= 1'b1;
        end else begin
`ifdef RD_FWFT_EN
            // Held word consumed with nothing behind it in memory.
            if (rinc) rvalid <= 1'b0;
`else
            rvalid <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (ADDRSIZE=4, DATASIZE=8).
// Covers the standard mode by default, and FWFT mode when RD_FWFT_EN is defined.
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       rinc;
    logic [4:0] rwptr;
    logic [7:0] rmem_data;
    logic [3:0] raddr;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rempty;
    logic [4:0] rptr;
    logic [4:0] rlevel;

    logic [7:0] mem [16];
    int total = 0;
    int bad   = 0;

    assign rmem_data = mem[raddr];

    always #5 rclk = ~rclk;

    fifo_rd_ctrl #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .rclk(rclk), .rrst(rrst), .rinc(rinc), .rwptr(rwptr),
        .rmem_data(rmem_data), .raddr(raddr), .rdata(rdata),
        .rvalid(rvalid), .rempty(rempty), .rptr(rptr), .rlevel(rlevel)
    );

    function automatic logic [4:0] gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] nxt;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset with concurrent rinc and a nonzero write pointer.
        rrst  = 1'b1;
        rinc  = 1'b1;
        rwptr = 5'h05;
        mem[0] = 8'h33;
        tick();
        tick();
        chk("rst_rempty", rempty, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rptr",   rptr,   5'h00);
        chk("rst_raddr",  raddr,  4'h0);
        chk("rst_rlevel", rlevel, 5'h00);
        chk("rst_rdata",  rdata,  8'h00);

`ifdef RD_FWFT_EN
        // Three words written, rinc held low: head word falls through.
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        rrst = 1'b0; rinc = 1'b0; rwptr = gray(5'd3);
        tick(); tick();
        chk("fw_empty_e2", rempty, 1);
        chk("fw_rvalid_e2", rvalid, 0);
        tick();
        chk("fw_empty_e3", rempty, 0);
        chk("fw_level_e3", rlevel, 3);
        tick();
        chk("fw_rvalid_e4", rvalid, 1);
        chk("fw_rdata_e4",  rdata,  8'h11);
        chk("fw_level_e4",  rlevel, 2);
        tick(); tick();
        chk("fw_hold_rvalid", rvalid, 1);
        chk("fw_hold_rdata",  rdata,  8'h11);
        chk("fw_hold_rptr",   rptr,   gray(5'd1));
        rinc = 1'b1;
        tick();
        chk("fw_w1_rdata",  rdata,  8'h22);
        chk("fw_w1_rvalid", rvalid, 1);
        tick();
        chk("fw_w2_rdata",  rdata,  8'h33);
        chk("fw_w2_rvalid", rvalid, 1);
        chk("fw_w2_rempty", rempty, 1);
        tick();
        chk("fw_done_rvalid", rvalid, 0);
        chk("fw_done_rptr",   rptr,   gray(5'd3));
        rinc = 1'b0;
`else
        // Fill latency: one word appears, empty drops on the third edge.
        rrst = 1'b0; rinc = 1'b0; rwptr = 5'h00;
        tick();
        chk("idle_rempty", rempty, 1);
        mem[0] = 8'hA5;
        rwptr  = 5'h01;
        tick();
        chk("lat_e1", rempty, 1);
        tick();
        chk("lat_e2", rempty, 1);
        tick();
        chk("lat_e3_rempty", rempty, 0);
        chk("lat_e3_rlevel", rlevel, 1);

        // Standard read, then a second rinc that must be ignored.
        rinc = 1'b1;
        tick();
        chk("rd_rdata",  rdata,  8'hA5);
        chk("rd_rvalid", rvalid, 1);
        chk("rd_rptr",   rptr,   5'h01);
        chk("rd_raddr",  raddr,  4'h1);
        chk("rd_rempty", rempty, 1);
        chk("rd_rlevel", rlevel, 0);
        mem[1] = 8'h5A;
        tick();
        chk("ign_rvalid", rvalid, 0);
        chk("ign_rdata",  rdata,  8'hA5);
        chk("ign_rptr",   rptr,   5'h01);
        rinc = 1'b0;

        // Full: write pointer 16 words ahead, then drain it.
        rrst = 1'b1; rwptr = 5'h18;
        tick();
        rrst = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
        tick(); tick(); tick();
        chk("full_rlevel", rlevel, 16);
        chk("full_rempty", rempty, 0);
        rinc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("drain_rdata",  rdata,  8'h40 + 8'(i));
            chk("drain_rptr",   rptr,   gray(5'(i + 1)));
            chk("drain_rempty", rempty, (i == 15));
            chk("drain_rlevel", rlevel, 15 - i);
        end
        tick();
        chk("drain_ovr_rvalid", rvalid, 0);
        chk("drain_ovr_rptr",   rptr,   5'h18);
        rinc = 1'b0;

        // Wrap: 32 single-word write/read round trips from reset.
        rrst = 1'b1; rwptr = 5'h00;
        tick();
        rrst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            nxt = 5'(k + 1);
            mem[k % 16] = 8'(k ^ 8'h5C);
            rwptr = gray(nxt);
            tick(); tick(); tick();
            chk("wrap_avail", rempty, 0);
            chk("wrap_level1", rlevel, 1);
            rinc = 1'b1;
            tick();
            rinc = 1'b0;
            chk("wrap_rdata",  rdata,  8'(k ^ 8'h5C));
            chk("wrap_rptr",   rptr,   gray(nxt));
            chk("wrap_rempty", rempty, 1);
            chk("wrap_level0", rlevel, 0);
            if (k == 30) chk("wrap_rptr_1f", rptr, 5'h10);
            if (k == 31) chk("wrap_raddr_0", raddr, 4'h0);
        end
        chk("wrap_end_rptr", rptr, 5'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
